// File: rtl/settings_menu_ctrl_pkg.sv
// Shared constants and types for the colour-theme settings screen.
//   - button bit indices, tile encodings, direction codes
//   - theme palette as packed {trim, bkg} pairs and its lookup function
//   - default auto-repeat timing
package menu_pkg;

    localparam int unsigned BTN_W   = 8;
    localparam int unsigned TILE_W  = 2;
    localparam int unsigned COLOR_W = 12;

    localparam int unsigned BTN_UP    = 0;
    localparam int unsigned BTN_DOWN  = 1;
    localparam int unsigned BTN_LEFT  = 2;
    localparam int unsigned BTN_RIGHT = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_START = 6;
    localparam int unsigned BTN_SEL   = 7;

    localparam logic [TILE_W-1:0] TILE_A = 2'b00;
    localparam logic [TILE_W-1:0] TILE_B = 2'b01;
    localparam logic [TILE_W-1:0] TILE_C = 2'b10;
    localparam logic [TILE_W-1:0] TILE_D = 2'b11;

    // Direction codes double as the button bit index of that direction.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int unsigned REPEAT_DELAY_DEF = 20;
    localparam int unsigned REPEAT_RATE_DEF  = 6;

    typedef struct packed {
        logic [COLOR_W-1:0] trim;
        logic [COLOR_W-1:0] bkg;
    } theme_t;

    localparam theme_t THEME_A = 24'h000FFF;
    localparam theme_t THEME_B = 24'hFFF000;
    localparam theme_t THEME_C = 24'h0F0020;
    localparam theme_t THEME_D = 24'hFA0310;

    function automatic theme_t theme_lookup(input logic [TILE_W-1:0] tile);
        case (tile)
            TILE_A:  return THEME_A;
            TILE_B:  return THEME_B;
            TILE_C:  return THEME_C;
            default: return THEME_D;
        endcase
    endfunction

    // Priority up > down > left > right over a 4-bit direction vector.
    function automatic logic [1:0] prio_dir(input logic [3:0] v);
        if (v[BTN_UP])        return DIR_UP;
        else if (v[BTN_DOWN]) return DIR_DOWN;
        else if (v[BTN_LEFT]) return DIR_LEFT;
        else                  return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/settings_menu_ctrl_if.sv
// Controller/renderer-facing signal bundle of the settings screen.
//   slave  : the controller (samples buttons/screenEnd/fsm_en, drives cursor/theme/done)
//   master : the environment driving the inputs and consuming the outputs
interface settings_menu_ctrl_if;
    import menu_pkg::*;

    logic [BTN_W-1:0]   buttons;
    logic               screenEnd;
    logic               fsm_en;
    logic [TILE_W-1:0]  sel;
    logic [TILE_W-1:0]  chc;
    logic [COLOR_W-1:0] color0;
    logic [COLOR_W-1:0] color1;
    logic               done;

    modport slave (
        input  buttons, screenEnd, fsm_en,
        output sel, chc, color0, color1, done
    );

    modport master (
        output buttons, screenEnd, fsm_en,
        input  sel, chc, color0, color1, done
    );

endinterface

// File: rtl/settings_menu_ctrl_frame_button_repeat.sv
// Per-frame button edge detection and direction auto-repeat.
//   in : clk25, reset, fsm_en, tick (frame strobe), buttons
//   out: press_c   press edges this tick (zero off-tick)
//        dir_evt_c direction event this tick (press edge or repeat fire)
//        dir_c     direction of that event
module frame_button_repeat
    import menu_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic             clk25,
    input  logic             reset,
    input  logic             fsm_en,
    input  logic             tick,
    input  logic [BTN_W-1:0] buttons,
    output logic [BTN_W-1:0] press_c,
    output logic             dir_evt_c,
    output logic [1:0]       dir_c
);

    localparam int unsigned CNT_W  = $clog2(REPEAT_DELAY + 1);
    // After a fire the counter restarts here so the next fire lands REPEAT_RATE ticks later;
    // the counter therefore never exceeds REPEAT_DELAY.
    localparam int unsigned RELOAD = (REPEAT_RATE < REPEAT_DELAY) ? (REPEAT_DELAY - REPEAT_RATE) : 0;

    logic [BTN_W-1:0] prev;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       trk_dir;
    logic             trk_vld;

    logic [BTN_W-1:0] edge_c;
    logic [3:0]       dir_edge_c;
    logic             held_any_c;
    logic [1:0]       held_dir_c;
    logic             same_dir_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             fire_c;

    // Edge detect, priority encode and repeat fire decision.
    always_comb begin
        edge_c     = buttons & ~prev;
        dir_edge_c = edge_c[3:0];
        held_any_c = |buttons[3:0];
        held_dir_c = prio_dir(buttons[3:0]);
        same_dir_c = trk_vld && (trk_dir == held_dir_c) && !dir_edge_c[held_dir_c];
        cnt_inc_c  = cnt + CNT_W'(1);
        fire_c     = held_any_c && same_dir_c && (cnt_inc_c == CNT_W'(REPEAT_DELAY));
        press_c    = tick ? edge_c : '0;
        dir_evt_c  = tick && ((|dir_edge_c) || fire_c);
        dir_c      = (|dir_edge_c) ? prio_dir(dir_edge_c) : held_dir_c;
    end

    // prev forced high while disabled so an already-held button is not a press.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            prev    <= '1;
            cnt     <= '0;
            trk_dir <= DIR_UP;
            trk_vld <= 1'b0;
        end else if (!fsm_en) begin
            prev    <= '1;
            cnt     <= '0;
            trk_vld <= 1'b0;
        end else if (tick) begin
            prev <= buttons;
            if (!held_any_c) begin
                cnt     <= '0;
                trk_vld <= 1'b0;
            end else if (!same_dir_c) begin
                cnt     <= '0;
                trk_dir <= held_dir_c;
                trk_vld <= 1'b1;
            end else if (fire_c) begin
                cnt <= CNT_W'(RELOAD);
            end else begin
                cnt <= cnt_inc_c;
            end
        end
    end

endmodule

// File: rtl/settings_menu_ctrl.sv
// Frame-synchronous 2x2 colour-theme selection controller.
//   in : clk25, reset (async, active-high)
//   bus: buttons, screenEnd, fsm_en -> sel, chc, color0 (trim), color1 (bkg), done
module settings_menu_ctrl
    import menu_pkg::*;
#(
    parameter int unsigned REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic                clk25,
    input  logic                reset,
    settings_menu_ctrl_if.slave bus
);

    logic             tick_c;
    logic [BTN_W-1:0] press_c;
    logic             dir_evt_c;
    logic [1:0]       dir_c;
    logic [5:0]       press_unused_c;

    logic [TILE_W-1:0] sel_q,   sel_nxt;
    logic [TILE_W-1:0] chc_q,   chc_nxt;
    theme_t            theme_q, theme_nxt;
    logic              done_q,  done_nxt;

    assign tick_c         = bus.screenEnd & bus.fsm_en;
    assign press_unused_c = {press_c[BTN_SEL], press_c[BTN_START], press_c[3:0]};

    frame_button_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_rep (
        .clk25     (clk25),
        .reset     (reset),
        .fsm_en    (bus.fsm_en),
        .tick      (tick_c),
        .buttons   (bus.buttons),
        .press_c   (press_c),
        .dir_evt_c (dir_evt_c),
        .dir_c     (dir_c)
    );

    // One action per tick: back > confirm > cursor move (clamped, no wrap).
    always_comb begin
        sel_nxt   = sel_q;
        chc_nxt   = chc_q;
        theme_nxt = theme_q;
        done_nxt  = 1'b0;
        if (tick_c) begin
            if (press_c[BTN_B]) begin
                done_nxt = 1'b1;
            end else if (press_c[BTN_A]) begin
                chc_nxt   = sel_q;
                theme_nxt = theme_lookup(sel_q);
            end else if (dir_evt_c) begin
                case (dir_c)
                    DIR_UP:    sel_nxt[1] = 1'b0;
                    DIR_DOWN:  sel_nxt[1] = 1'b1;
                    DIR_LEFT:  sel_nxt[0] = 1'b0;
                    default:   sel_nxt[0] = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            sel_q   <= TILE_A;
            chc_q   <= TILE_A;
            theme_q <= THEME_A;
            done_q  <= 1'b0;
        end else begin
            sel_q   <= sel_nxt;
            chc_q   <= chc_nxt;
            theme_q <= theme_nxt;
            done_q  <= done_nxt;
        end
    end

    assign bus.sel    = sel_q;
    assign bus.chc    = chc_q;
    assign bus.color0 = theme_q.trim;
    assign bus.color1 = theme_q.bkg;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_settings_menu_ctrl.sv
// Directed bench for settings_menu_ctrl with REPEAT_DELAY=3, REPEAT_RATE=2.
module tb_settings_menu_ctrl;
    import menu_pkg::*;

    logic clk25 = 1'b0;
    logic reset;
    logic evt_seen;
    int   checks   = 0;
    int   failures = 0;

    settings_menu_ctrl_if bus();

    settings_menu_ctrl #(
        .REPEAT_DELAY (3),
        .REPEAT_RATE  (2)
    ) dut (
        .clk25 (clk25),
        .reset (reset),
        .bus   (bus)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] s, input logic [1:0] c,
                           input logic [11:0] c0, input logic [11:0] c1, input logic d);
        chk({tag, ".sel"},    12'(bus.sel),  12'(s));
        chk({tag, ".chc"},    12'(bus.chc),  12'(c));
        chk({tag, ".color0"}, bus.color0,    c0);
        chk({tag, ".color1"}, bus.color1,    c1);
        chk({tag, ".done"},   12'(bus.done), 12'(d));
    endtask

    // One idle cycle, then a single-cycle screenEnd with buttons b; samples the
    // direction event just before the tick edge, returns #1 after it.
    task automatic frame(input logic [7:0] b);
        @(negedge clk25);
        @(negedge clk25);
        bus.buttons   = b;
        bus.screenEnd = 1'b1;
        #10 evt_seen  = dut.u_rep.dir_evt_c;
        @(posedge clk25);
        #1 bus.screenEnd = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.buttons   = 8'h00;
        bus.screenEnd = 1'b0;
        bus.fsm_en    = 1'b0;
        repeat (3) @(posedge clk25);
        #1 chk_all("reset", 2'b00, 2'b00, 12'h000, 12'hFFF, 1'b0);
        @(negedge clk25) reset = 1'b0;

        // Idle ticks
        bus.fsm_en = 1'b1;
        frame(8'h00);
        frame(8'h00);
        chk_all("idle", 2'b00, 2'b00, 12'h000, 12'hFFF, 1'b0);

        // Right, down, then right into the wall
        frame(8'h08); chk("right.sel", 12'(bus.sel), 12'h1);
        frame(8'h00);
        frame(8'h02); chk("down.sel", 12'(bus.sel), 12'h3);
        frame(8'h00);
        frame(8'h08); chk("right_wall.sel", 12'(bus.sel), 12'h3);
        frame(8'h00);
        chk_all("pre_commit", 2'b11, 2'b00, 12'h000, 12'hFFF, 1'b0);

        // Commit tile D
        frame(8'h10);
        chk_all("commit_d", 2'b11, 2'b11, 12'hFA0, 12'h310, 1'b0);
        frame(8'h00);

        // Up to tile B, then hold left: press move, clamp, repeat at tick 3
        frame(8'h01); chk("up.sel", 12'(bus.sel), 12'h1);
        frame(8'h00);
        frame(8'h04); chk("left0.evt", 12'(evt_seen), 12'h1); chk("left0.sel", 12'(bus.sel), 12'h0);
        frame(8'h04); chk("left1.evt", 12'(evt_seen), 12'h0);
        frame(8'h04); chk("left2.evt", 12'(evt_seen), 12'h0);
        frame(8'h04); chk("left3.evt", 12'(evt_seen), 12'h1); chk("left3.sel", 12'(bus.sel), 12'h0);

        // Add down: becomes highest priority, counter restarts
        frame(8'h06); chk("down0.evt", 12'(evt_seen), 12'h1); chk("down0.sel", 12'(bus.sel), 12'h2);
        frame(8'h06); chk("down1.evt", 12'(evt_seen), 12'h0);
        frame(8'h06); chk("down2.evt", 12'(evt_seen), 12'h0);
        frame(8'h06); chk("down3.evt", 12'(evt_seen), 12'h1);
        frame(8'h06); chk("down4.evt", 12'(evt_seen), 12'h0);
        frame(8'h06); chk("down5.evt", 12'(evt_seen), 12'h1); chk("down5.sel", 12'(bus.sel), 12'h2);
        frame(8'h00); chk("release.evt", 12'(evt_seen), 12'h0);

        // screenEnd while disabled is ignored
        @(negedge clk25) bus.fsm_en = 1'b0;
        frame(8'h08);
        chk_all("disabled", 2'b10, 2'b11, 12'hFA0, 12'h310, 1'b0);

        // A held as the screen enables: no commit until released and pressed again
        @(negedge clk25);
        bus.buttons = 8'h10;
        bus.fsm_en  = 1'b1;
        frame(8'h10); chk("a_held0.chc", 12'(bus.chc), 12'h3);
        frame(8'h10); chk("a_held1.chc", 12'(bus.chc), 12'h3);
        frame(8'h00);
        frame(8'h10);
        chk_all("commit_c", 2'b10, 2'b10, 12'h0F0, 12'h020, 1'b0);
        frame(8'h00);

        // B and right together: done for one cycle, cursor unmoved
        frame(8'h28);
        chk_all("back", 2'b10, 2'b10, 12'h0F0, 12'h020, 1'b1);
        @(posedge clk25);
        #1 chk("back_next.done", 12'(bus.done), 12'h0);

        // Asynchronous reset mid-frame
        @(negedge clk25);
        #5 reset = 1'b1;
        #2 chk_all("async_reset", 2'b00, 2'b00, 12'h000, 12'hFFF, 1'b0);
        @(negedge clk25) reset = 1'b0;

        // Held right after reset is not a press
        frame(8'h08); chk("post_reset_held.sel", 12'(bus.sel), 12'h0);
        frame(8'h00);
        frame(8'h08); chk("post_reset_press.sel", 12'(bus.sel), 12'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
